// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the 16-bit teaching core: opcodes, instruction
// field positions and FSM state encodings.
package cpu_isa_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_NOT  = 4'd4;
    localparam logic [3:0] OP_SHL  = 4'd5;
    localparam logic [3:0] OP_SHR  = 4'd6;
    localparam logic [3:0] OP_LDI  = 4'd7;
    localparam logic [3:0] OP_LD   = 4'd8;
    localparam logic [3:0] OP_ST   = 4'd9;
    localparam logic [3:0] OP_BR   = 4'd10;
    localparam logic [3:0] OP_BZ   = 4'd11;
    localparam logic [3:0] OP_BN   = 4'd12;
    localparam logic [3:0] OP_JAL  = 4'd13;
    localparam logic [3:0] OP_JR   = 4'd14;
    localparam logic [3:0] OP_QUIT = 4'd15;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RA_MSB  = 7;
    localparam int RA_LSB  = 4;
    localparam int RB_MSB  = 3;
    localparam int RB_LSB  = 0;
    localparam int OFF_MSB = 11;
    localparam int OFF_LSB = 4;
    localparam int IMM_MSB = 11;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_LOAD   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for opcodes ADD..SHR; shifts are logical and take the
// shift amount straight from the instruction's low nibble.
module cpu_alu
    import cpu_isa_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic [3:0]  i_shamt,
    output logic [15:0] o_y
);

    // Opcode-selected result, zero for non-ALU opcodes
    always_comb begin
        o_y = 16'h0000;
        case (i_op)
            OP_ADD:  o_y = i_a + i_b;
            OP_SUB:  o_y = i_a - i_b;
            OP_AND:  o_y = i_a & i_b;
            OP_OR:   o_y = i_a | i_b;
            OP_NOT:  o_y = ~i_a;
            OP_SHL:  o_y = i_a << i_shamt;
            OP_SHR:  o_y = i_a >> i_shamt;
            default: o_y = 16'h0000;
        endcase
    end

endmodule

// File: rtl/cpu_core.sv
// Multicycle fetch/decode/execute core driving a single-port RAM with
// one-cycle read latency; register file, PC and address muxing live here.
module cpu_core
    import cpu_isa_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          LINK_REG = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_mem_wdata,
    output logic        o_mem_we,
    input  logic [15:0] i_mem_rdata,
    output logic        o_halted,
    output logic [15:0] o_pc,
    input  logic [3:0]  i_dbg_sel,
    output logic [15:0] o_dbg_val
);

    localparam logic [3:0] LINK_IDX = 4'(LINK_REG);

    state_t      r_state;
    logic [15:0] r_pc;
    logic [15:0] r_ir;
    logic [15:0] r_regs [16];
    logic        r_halted;

    logic [3:0]  w_op, w_rd, w_ra, w_rb;
    logic [15:0] w_a, w_b, w_alu_y;
    logic [15:0] w_ld_ea, w_st_ea;
    logic [15:0] w_pc_inc, w_br_tgt, w_pc_next;
    logic        w_is_ld, w_is_st;

    assign w_op     = r_ir[OP_MSB:OP_LSB];
    assign w_rd     = r_ir[RD_MSB:RD_LSB];
    assign w_ra     = r_ir[RA_MSB:RA_LSB];
    assign w_rb     = r_ir[RB_MSB:RB_LSB];
    assign w_a      = r_regs[w_ra];
    assign w_b      = r_regs[w_rb];
    assign w_ld_ea  = w_b + {12'h000, w_ra};
    assign w_st_ea  = w_b + {12'h000, w_rd};
    assign w_pc_inc = r_pc + 16'd1;
    assign w_br_tgt = r_pc + sext8(r_ir[OFF_MSB:OFF_LSB]);
    assign w_is_ld  = (r_state == ST_EXEC) && (w_op == OP_LD);
    assign w_is_st  = (r_state == ST_EXEC) && (w_op == OP_ST);

    cpu_alu u_alu (
        .i_op    (w_op),
        .i_a     (w_a),
        .i_b     (w_b),
        .i_shamt (w_rb),
        .o_y     (w_alu_y)
    );

    // Next PC for an instruction completing in EXEC
    always_comb begin
        w_pc_next = w_pc_inc;
        case (w_op)
            OP_BR:   w_pc_next = w_br_tgt;
            OP_BZ:   w_pc_next = (w_b == 16'h0000) ? w_br_tgt : w_pc_inc;
            OP_BN:   w_pc_next = w_b[15] ? w_br_tgt : w_pc_inc;
            OP_JAL:  w_pc_next = {4'h0, r_ir[IMM_MSB:0]};
            OP_JR:   w_pc_next = w_a;
            default: w_pc_next = w_pc_inc;
        endcase
    end

    // RAM address: effective address only during EXEC of LD/ST
    always_comb begin
        if (w_is_ld) begin
            o_mem_addr = w_ld_ea;
        end else if (w_is_st) begin
            o_mem_addr = w_st_ea;
        end else begin
            o_mem_addr = r_pc;
        end
    end

    assign o_mem_we    = w_is_st;
    assign o_mem_wdata = w_a;
    assign o_halted    = r_halted;
    assign o_pc        = r_pc;
    assign o_dbg_val   = r_regs[i_dbg_sel];

    // Control FSM, PC, IR and register-file writeback
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_FETCH;
            r_pc     <= RESET_PC;
            r_ir     <= 16'h0000;
            r_halted <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= 16'h0000;
            end
        end else begin
            case (r_state)
                ST_FETCH: r_state <= ST_DECODE;
                ST_DECODE: begin
                    r_ir    <= i_mem_rdata;
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    case (w_op)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_SHL, OP_SHR: begin
                            r_regs[w_rd] <= w_alu_y;
                            r_pc         <= w_pc_next;
                            r_state      <= ST_FETCH;
                        end
                        OP_LDI: begin
                            r_regs[w_rd] <= {8'h00, r_ir[7:0]};
                            r_pc         <= w_pc_next;
                            r_state      <= ST_FETCH;
                        end
                        OP_LD: r_state <= ST_LOAD;
                        OP_JAL: begin
                            r_regs[LINK_IDX] <= w_pc_inc;
                            r_pc             <= w_pc_next;
                            r_state          <= ST_FETCH;
                        end
                        OP_QUIT: begin
                            r_halted <= 1'b1;
                            r_state  <= ST_HALT;
                        end
                        default: begin
                            r_pc    <= w_pc_next;
                            r_state <= ST_FETCH;
                        end
                    endcase
                end
                ST_LOAD: begin
                    r_regs[w_rd] <= i_mem_rdata;
                    r_pc         <= w_pc_inc;
                    r_state      <= ST_FETCH;
                end
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_core.sv
// Self-checking bench for cpu_core: directed programs plus random programs,
// all compared against an instruction-level reference model.
module tb_cpu_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] mem_addr, mem_wdata, rdata, pc, dbg_val;
    logic        mem_we, halted;
    logic [3:0]  dbg_sel;

    logic [15:0] mem [65536];
    logic [15:0] img [65536];
    logic [15:0] mm  [65536];
    logic        tb_load, we_clr;
    int          we_cnt;

    logic [15:0] m_r [16];
    logic [15:0] m_pc;
    int          m_cyc, m_st;
    bit          m_halt;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc;

    always #5 clk = ~clk;

    cpu_core #(.RESET_PC(16'h0000), .LINK_REG(15)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_mem_we    (mem_we),
        .i_mem_rdata (rdata),
        .o_halted    (halted),
        .o_pc        (pc),
        .i_dbg_sel   (dbg_sel),
        .o_dbg_val   (dbg_val)
    );

    // RAM model with one-cycle read latency, plus image load and write counting
    always @(posedge clk) begin
        if (tb_load) begin
            for (int i = 0; i < 65536; i++) mem[i] <= img[i];
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        rdata <= mem[mem_addr];
        if (we_clr) we_cnt <= 0;
        else if (mem_we) we_cnt <= we_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Instruction-level reference: each instruction is 3 cycles, LD is 4
    task automatic iss_run(input int max_steps);
        logic [15:0] ir, nx, ea;
        logic [3:0]  op, d, a, b;
        for (int i = 0; i < 65536; i++) mm[i] = img[i];
        for (int i = 0; i < 16; i++) m_r[i] = 16'h0000;
        m_pc = 16'h0000; m_cyc = 0; m_st = 0; m_halt = 1'b0;
        for (int s = 0; s < max_steps && !m_halt; s++) begin
            ir = mm[m_pc];
            op = ir[15:12]; d = ir[11:8]; a = ir[7:4]; b = ir[3:0];
            nx = m_pc + 16'd1;
            m_cyc += 3;
            case (op)
                4'd0:  m_r[d] = m_r[a] + m_r[b];
                4'd1:  m_r[d] = m_r[a] - m_r[b];
                4'd2:  m_r[d] = m_r[a] & m_r[b];
                4'd3:  m_r[d] = m_r[a] | m_r[b];
                4'd4:  m_r[d] = ~m_r[a];
                4'd5:  m_r[d] = m_r[a] << b;
                4'd6:  m_r[d] = m_r[a] >> b;
                4'd7:  m_r[d] = {8'h00, ir[7:0]};
                4'd8:  begin ea = m_r[b] + {12'h000, a}; m_r[d] = mm[ea]; m_cyc += 1; end
                4'd9:  begin ea = m_r[b] + {12'h000, d}; mm[ea] = m_r[a]; m_st++; end
                4'd10: nx = m_pc + {{8{ir[11]}}, ir[11:4]};
                4'd11: if (m_r[b] == 16'h0000) nx = m_pc + {{8{ir[11]}}, ir[11:4]};
                4'd12: if (m_r[b][15]) nx = m_pc + {{8{ir[11]}}, ir[11:4]};
                4'd13: begin m_r[15] = nx; nx = {4'h0, ir[11:0]}; end
                4'd14: nx = m_r[a];
                default: begin m_halt = 1'b1; nx = m_pc; end
            endcase
            m_pc = nx;
        end
    endtask

    task automatic clr_img();
        for (int i = 0; i < 65536; i++) img[i] = 16'h0000;
    endtask

    task automatic read_reg(input int i, output logic [15:0] v);
        dbg_sel = 4'(i);
        #1 v = dbg_val;
    endtask

    // Hold reset, load the image into RAM and compute the expected outcome
    task automatic prep();
        rst_n = 1'b0; tb_load = 1'b1; we_clr = 1'b1;
        @(posedge clk); #1;
        tb_load = 1'b0; we_clr = 1'b0;
        iss_run(400);
    endtask

    task automatic compare_final(input string tag);
        logic [15:0] v;
        int d;
        check_eq({tag, ".halted"}, 16'(halted), 16'd1);
        check_eq({tag, ".pc"}, pc, m_pc);
        check_eq({tag, ".we"}, 16'(mem_we), 16'd0);
        check_eq({tag, ".stores"}, 16'(we_cnt), 16'(m_st));
        for (int i = 0; i < 16; i++) begin
            read_reg(i, v);
            check_eq($sformatf("%s.r%0d", tag, i), v, m_r[i]);
        end
        d = 0;
        for (int i = 0; i < 65536; i++) if (mem[i] !== mm[i]) d++;
        check_eq({tag, ".memdiff"}, 16'(d), 16'd0);
    endtask

    task automatic go_and_finish(input string tag);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_eq({tag, ".fetch0"}, mem_addr, 16'h0000);
        cyc = 0;
        while (!halted && cyc < 3000) begin
            @(posedge clk); cyc++;
            @(negedge clk);
        end
        check_eq({tag, ".cycles"}, 16'(cyc), 16'(m_cyc));
        compare_final(tag);
    endtask

    logic [15:0] v;
    logic [15:0] hold_pc;
    int          bad, n;
    logic [3:0]  rop;

    initial begin
        rst_n = 1'b0; tb_load = 1'b0; we_clr = 1'b0; dbg_sel = 4'h0;

        // Multiply 3*5 via a subroutine
        clr_img();
        img[0] = 16'h7720; img[1] = 16'h8107; img[2] = 16'h8217; img[3] = 16'hD006;
        img[4] = 16'h9237; img[5] = 16'hF000; img[6] = 16'h7300; img[7] = 16'h7401;
        img[8] = 16'hB042; img[9] = 16'h0331; img[10] = 16'h1224; img[11] = 16'hAFD0;
        img[12] = 16'hE0F0; img[32] = 16'd3; img[33] = 16'd5;
        prep();
        check_eq("reset.pc", pc, 16'h0000);
        check_eq("reset.halted", 16'(halted), 16'd0);
        check_eq("reset.we", 16'(mem_we), 16'd0);
        check_eq("reset.addr", mem_addr, 16'h0000);
        read_reg(15, v); check_eq("reset.r15", v, 16'h0000);
        go_and_finish("mul");
        check_eq("mul.m34", mem[34], 16'd15);
        check_eq("mul.pc5", pc, 16'd5);
        read_reg(15, v); check_eq("mul.r15", v, 16'd4);

        // Halt is absorbing
        hold_pc = pc; bad = 0;
        repeat (50) begin
            @(posedge clk); @(negedge clk);
            if (!halted || pc !== hold_pc || mem_we) bad++;
        end
        check_eq("hold.stable", 16'(bad), 16'd0);
        compare_final("hold");

        // ALU and conditional branches
        clr_img();
        img[0] = 16'h7104; img[1] = 16'h7205; img[2] = 16'h0312; img[3] = 16'h5434;
        img[4] = 16'h6545; img[5] = 16'h7680; img[6] = 16'h5768; img[7] = 16'hB027;
        img[8] = 16'h7801; img[9] = 16'hB029; img[10] = 16'h7A01; img[11] = 16'hC029;
        img[12] = 16'h7B01; img[13] = 16'hC027; img[14] = 16'h7C01; img[15] = 16'hF000;
        prep(); go_and_finish("arith");
        read_reg(3, v);  check_eq("arith.add", v, 16'd9);
        read_reg(4, v);  check_eq("arith.shl", v, 16'h0090);
        read_reg(5, v);  check_eq("arith.shr", v, 16'd4);
        read_reg(7, v);  check_eq("arith.shl8", v, 16'h8000);
        read_reg(8, v);  check_eq("arith.bz_nt", v, 16'd1);
        read_reg(10, v); check_eq("arith.bz_t", v, 16'd0);
        read_reg(11, v); check_eq("arith.bn_nt", v, 16'd1);
        read_reg(12, v); check_eq("arith.bn_t", v, 16'd0);
        check_eq("arith.pc", pc, 16'd15);

        // Store/load round trip
        clr_img();
        img[0] = 16'h7280; img[1] = 16'h7105; img[2] = 16'h9F12; img[3] = 16'h86F2; img[4] = 16'hF000;
        prep(); go_and_finish("stld");
        check_eq("stld.m8f", mem[16'h008F], 16'd5);
        read_reg(6, v); check_eq("stld.r6", v, 16'd5);
        check_eq("stld.we1", 16'(we_cnt), 16'd1);
        check_eq("stld.cyc", 16'(cyc), 16'd16);

        // Branch target wraps below zero
        clr_img();
        img[0] = 16'hAFF0; img[16'hFFFF] = 16'hF000;
        prep(); go_and_finish("brwrap");
        check_eq("brwrap.pc", pc, 16'hFFFF);

        // Addition wraps
        clr_img();
        img[0] = 16'h4100; img[1] = 16'h7201; img[2] = 16'h0312; img[3] = 16'hF000;
        prep(); go_and_finish("addwrap");
        read_reg(3, v); check_eq("addwrap.r3", v, 16'h0000);

        // Reset during EXEC of a store
        clr_img();
        img[0] = 16'h7280; img[1] = 16'h7105; img[2] = 16'h9F12; img[3] = 16'hF000;
        prep();
        @(negedge clk); rst_n = 1'b1; n = 0;
        while (!mem_we && n < 100) begin @(posedge clk); @(negedge clk); n++; end
        check_eq("rst_st.exec_cyc", 16'(n), 16'd8);
        check_eq("rst_st.addr", mem_addr, 16'h008F);
        check_eq("rst_st.wdata", mem_wdata, 16'd5);
        rst_n = 1'b0;
        #1 check_eq("rst_st.we_low", 16'(mem_we), 16'd0);
        @(posedge clk); @(negedge clk);
        check_eq("rst_st.nowrite", mem[16'h008F], 16'h0000);
        check_eq("rst_st.pc", pc, 16'h0000);
        read_reg(1, v); check_eq("rst_st.r1", v, 16'h0000);
        go_and_finish("rst_st_rerun");

        // Reset during LOAD
        clr_img();
        img[0] = 16'h7280; img[1] = 16'h86F2; img[2] = 16'hF000; img[16'h008F] = 16'd5;
        prep();
        @(negedge clk); rst_n = 1'b1;
        repeat (5) begin @(posedge clk); @(negedge clk); end
        check_eq("rst_ld.ea", mem_addr, 16'h008F);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        read_reg(6, v); check_eq("rst_ld.r6", v, 16'h0000);
        check_eq("rst_ld.pc", pc, 16'h0000);
        go_and_finish("rst_ld_rerun");

        // Random straight-line programs with short forward branches
        for (int t = 0; t < 20; t++) begin
            for (int tries = 0; tries < 10; tries++) begin
                clr_img();
                for (int a = 0; a < 24; a++) begin
                    rop = 4'($urandom_range(0, 12));
                    if (rop >= 4'd10)
                        img[a] = {rop, 8'($urandom_range(1, 3)), 4'($urandom)};
                    else
                        img[a] = {rop, 12'($urandom)};
                end
                for (int a = 24; a < 28; a++) img[a] = 16'hF000;
                for (int a = 32; a < 256; a++) img[a] = 16'($urandom);
                iss_run(400);
                if (m_halt) break;
            end
            prep();
            go_and_finish($sformatf("rnd%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
